// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared types and constants for the SOPC memory arbiter: FSM states, grant IDs,
// wait-state range limits.
package sopc_mem_arbiter_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } arb_state_e;

  typedef enum logic {
    GNT_D = 1'b0,
    GNT_I = 1'b1
  } grant_e;

  // Bit positions of each port in request/done vectors; match grant_e values.
  localparam int unsigned IDX_D    = 0;
  localparam int unsigned IDX_I    = 1;
  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = 4;

  function automatic bit wait_cycles_ok(input int unsigned w);
    return w <= WAIT_MAX;
  endfunction

endpackage

// File: rtl/sopc_arb_grant.sv
// Grant selection between data and fetch ports. Optional macro SOPC_ARB_RR_EN selects
// round-robin with a pointer register; otherwise fixed data-over-fetch priority.
module sopc_arb_grant
  import sopc_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] done,
  output grant_e     gnt,
  output logic       gnt_valid
);

  assign gnt_valid = |req;

`ifdef SOPC_ARB_RR_EN
  // ptr_q names the port preferred on the next simultaneous request.
  grant_e ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (done[IDX_D]) begin
      ptr_d = GNT_I;
    end else if (done[IDX_I]) begin
      ptr_d = GNT_D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= GNT_D;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    gnt = GNT_I;
    if (req[IDX_D] && req[IDX_I]) begin
      gnt = ptr_q;
    end else if (req[IDX_D]) begin
      gnt = GNT_D;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, done};

  always_comb begin
    gnt = GNT_I;
    if (req[IDX_D]) begin
      gnt = GNT_D;
    end
  end
`endif

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Arbitrates core fetch and data ports onto one synchronous single-port memory with
// WAIT_CYCLES extra cycles per access. SOPC_ARB_RR_EN enables round-robin arbitration.
module sopc_mem_arbiter
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_ce,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_data,
  output logic                if_stall,
  input  logic                d_ce,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_sel,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned SEL_W = DATA_W / 8;

  if (!wait_cycles_ok(WAIT_CYCLES) || (DATA_W % 8) != 0) begin : g_param_check
    $error("sopc_mem_arbiter: WAIT_CYCLES must be 0..15 and DATA_W a multiple of 8");
  end

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  grant_e              grant_q, grant_d;
  logic                mem_ce_q, mem_ce_d;
  logic                mem_we_q, mem_we_d;
  logic [SEL_W-1:0]    mem_sel_q, mem_sel_d;
  logic [ADDR_W-3:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic [1:0]          done_q, done_d;

  logic [1:0]          req;
  grant_e              gnt;
  logic                gnt_valid;

  // A port whose done pulse is high is still holding its finished request; mask it so
  // the other port can be granted in the same cycle without re-issuing the old access.
  assign req = {if_ce, d_ce} & ~done_q;

  sopc_arb_grant u_grant (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done_q),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_data_d   = if_data_q;
    d_rdata_d   = d_rdata_q;
    done_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          state_d  = S_ACCESS;
          cnt_d    = CNT_W'(WAIT_CYCLES);
          grant_d  = gnt;
          mem_ce_d = 1'b1;
          if (gnt == GNT_D) begin
            mem_we_d    = d_we;
            mem_sel_d   = d_sel;
            mem_addr_d  = d_addr[ADDR_W-1:2];
            mem_wdata_d = d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_sel_d   = '1;
            mem_addr_d  = if_addr[ADDR_W-1:2];
            mem_wdata_d = '0;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          mem_ce_d = 1'b0;
          mem_we_d = 1'b0;
          if (grant_q == GNT_D) begin
            if (d_ce) begin
              done_d[IDX_D] = 1'b1;
              if (!mem_we_q) begin
                d_rdata_d = mem_rdata;
              end
            end
          end else if (if_ce) begin
            done_d[IDX_I] = 1'b1;
            if_data_d     = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      grant_q     <= GNT_D;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_data_q   <= if_data_d;
      d_rdata_q   <= d_rdata_d;
      done_q      <= done_d;
    end
  end

  // Stalls are gated by rst so every output reads 0 while reset is held.
  assign if_stall  = rst & if_ce & ~done_q[IDX_I];
  assign d_stall   = rst & d_ce  & ~done_q[IDX_D];
  assign if_data   = if_data_q;
  assign d_rdata   = d_rdata_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed self-checking bench for sopc_mem_arbiter (WAIT_CYCLES=1 and WAIT_CYCLES=0).
module tb_sopc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ce = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_ce = 1'b0;
  logic        d0_ce = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] if_data, d_rdata, mem_wdata;
  logic        if_stall, d_stall, mem_ce, mem_we;
  logic [3:0]  mem_sel;
  logic [29:0] mem_addr;

  logic [31:0] if0_data, d0_rdata, mem0_wdata;
  logic        if0_stall, d0_stall, mem0_ce, mem0_we;
  logic [3:0]  mem0_sel;
  logic [29:0] mem0_addr;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned n;

  always #5 clk = ~clk;

  sopc_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_ce(if_ce), .if_addr(if_addr), .if_data(if_data), .if_stall(if_stall),
    .d_ce(d_ce), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  sopc_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_ce(1'b0), .if_addr(if_addr), .if_data(if0_data), .if_stall(if0_stall),
    .d_ce(d0_ce), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d0_rdata), .d_stall(d0_stall),
    .mem_ce(mem0_ce), .mem_we(mem0_we), .mem_sel(mem0_sel), .mem_addr(mem0_addr),
    .mem_wdata(mem0_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_ce", 32'(mem_ce), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // T1: fetch only
    @(posedge clk); #1;
    if_ce = 1'b1; if_addr = 32'h0000_0010; mem_rdata = 32'h3401_1100;
    @(negedge clk);
    check("t1_stall_c0", 32'(if_stall), 32'h1);
    check("t1_idle_ce", 32'(mem_ce), 32'h0);
    @(negedge clk);
    check("t1_mem_ce", 32'(mem_ce), 32'h1);
    check("t1_mem_addr", 32'(mem_addr), 32'h4);
    check("t1_mem_sel", 32'(mem_sel), 32'hF);
    check("t1_mem_we", 32'(mem_we), 32'h0);
    check("t1_stall_c1", 32'(if_stall), 32'h1);
    @(negedge clk);
    check("t1_stall_c2", 32'(if_stall), 32'h1);
    @(negedge clk);
    check("t1_stall_c3", 32'(if_stall), 32'h0);
    check("t1_if_data", if_data, 32'h3401_1100);
    check("t1_ce_done", 32'(mem_ce), 32'h0);
    @(posedge clk); #1;
    if_ce = 1'b0;
    @(negedge clk);
    check("t1_no_reissue", 32'(mem_ce), 32'h0);

    // T4: both ports requesting continuously -> D,I,D,I
    @(posedge clk); #1;
    if_ce = 1'b1; if_addr = 32'h200; d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t4_grant%0d", k), 32'(mem_addr), (k % 2 == 0) ? 32'h40 : 32'h80);
      repeat (2) @(negedge clk);
    end
    if_ce = 1'b0; d_ce = 1'b0;

    // T3: simultaneous fetch + data read
    @(posedge clk); #1;
    if_ce = 1'b1; if_addr = 32'h44; d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    mem_rdata = 32'h1111_2222;
    @(negedge clk);
    @(negedge clk);
    check("t3_data_first", 32'(mem_addr), 32'h10);
    repeat (2) @(negedge clk);
    check("t3_d_stall", 32'(d_stall), 32'h0);
    check("t3_d_rdata", d_rdata, 32'h1111_2222);
    check("t3_if_wait", 32'(if_stall), 32'h1);
    @(posedge clk); #1;
    d_ce = 1'b0; mem_rdata = 32'h5555_6666;
    @(negedge clk);
    check("t3_fetch_addr", 32'(mem_addr), 32'h11);
    repeat (2) @(negedge clk);
    check("t3_if_stall", 32'(if_stall), 32'h0);
    check("t3_if_data", if_data, 32'h5555_6666);
    @(posedge clk); #1;
    if_ce = 1'b0;

    // T2: write
    @(posedge clk); #1;
    d_ce = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_sel = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'hCAFE_0000;
    @(negedge clk);
    @(negedge clk);
    check("t2_mem_we", 32'(mem_we), 32'h1);
    check("t2_mem_sel", 32'(mem_sel), 32'h3);
    check("t2_mem_addr", 32'(mem_addr), 32'h8);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t2_we_held", 32'(mem_we), 32'h1);
    @(negedge clk);
    check("t2_d_stall", 32'(d_stall), 32'h0);
    check("t2_rdata_kept", d_rdata, 32'h1111_2222);
    check("t2_we_idle", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    d_ce = 1'b0; d_we = 1'b0;

    // T4b: data served last, then both request; ce dropped mid-access
    @(posedge clk); #1;
    d_ce = 1'b1; d_addr = 32'h300; mem_rdata = 32'h7777_8888;
    repeat (4) @(negedge clk);
    check("t4b_d_done", 32'(d_stall), 32'h0);
    d_ce = 1'b0;
    @(posedge clk); #1;
    d_ce = 1'b1; if_ce = 1'b1; if_addr = 32'h400;
    repeat (2) @(negedge clk);
`ifdef SOPC_ARB_RR_EN
    check("t4b_rr_grant", 32'(mem_addr), 32'h100);
`else
    check("t4b_fixed_grant", 32'(mem_addr), 32'hC0);
`endif
    d_ce = 1'b0; if_ce = 1'b0; mem_rdata = 32'h9999_AAAA;
    repeat (2) @(negedge clk);
    check("t4b_drop_idle", 32'(mem_ce), 32'h0);
    check("t4b_drop_d", d_rdata, 32'h7777_8888);
    check("t4b_drop_i", if_data, 32'h5555_6666);

    // T5: reset during ACCESS
    @(posedge clk); #1;
    if_ce = 1'b1; if_addr = 32'h10;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_mem_ce", 32'(mem_ce), 32'h0);
    check("t5_mem_addr", 32'(mem_addr), 32'h0);
    check("t5_if_data", if_data, 32'h0);
    check("t5_d_rdata", d_rdata, 32'h0);
    check("t5_if_stall", 32'(if_stall), 32'h0);
    @(negedge clk);
    rst = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #1;
    n = 0;
    while (if_stall && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("t5_latency", n, 32'd3);
    check("t5_if_data_new", if_data, 32'h0BAD_F00D);
    if_ce = 1'b0;

    // T6: WAIT_CYCLES=0, good read then dropped request
    @(posedge clk); #1;
    d0_ce = 1'b1; d_we = 1'b0; d_addr = 32'h8; mem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    check("t6_stall_c0", 32'(d0_stall), 32'h1);
    @(negedge clk);
    check("t6_mem_ce", 32'(mem0_ce), 32'h1);
    check("t6_stall_c1", 32'(d0_stall), 32'h1);
    @(negedge clk);
    check("t6_done", 32'(d0_stall), 32'h0);
    check("t6_rdata", d0_rdata, 32'hA5A5_0001);
    d0_ce = 1'b0;
    @(posedge clk); #1;
    d0_ce = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    d0_ce = 1'b0;
    @(negedge clk);
    check("t6_drop_access", 32'(mem0_ce), 32'h1);
    @(negedge clk);
    check("t6_drop_idle", 32'(mem0_ce), 32'h0);
    check("t6_drop_rdata", d0_rdata, 32'hA5A5_0001);
    @(negedge clk);
    check("t6_no_restart", 32'(mem0_ce), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
